// File: rtl/pacote_memoria_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states and lane masks.
package pacote_memoria_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} estado_t;

    localparam logic [31:0] MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] MASK_HALF = 32'h0000_FFFF;
    localparam logic [31:0] MASK_WORD = 32'hFFFF_FFFF;

    // Bit offset of the addressed lane; halves only honour lane[1], words start at bit 0.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: lane_shift = {lane, 3'b000};
            SZ_HALF: lane_shift = {lane[1], 4'b0000};
            default: lane_shift = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/alinhador_dado.sv
// Combinational byte-lane logic: load extract with sign/zero extension and store merge
// of right-aligned write data into a full RAM word.
module alinhador_dado
    import pacote_memoria_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        signed_ld,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] mask;

    always_comb begin
        sh       = lane_shift(size, lane);
        shifted  = word >> sh;
        mask     = MASK_WORD;
        load_val = shifted;
        case (size)
            SZ_BYTE: begin
                mask     = MASK_BYTE << sh;
                load_val = {{24{signed_ld & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                mask     = MASK_HALF << sh;
                load_val = {{16{signed_ld & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
        merged = (word & ~mask) | ((wdata << sh) & mask);
    end

endmodule

// File: rtl/controlador_memoria_dado.sv
// Data-memory initiator: byte/half/word loads and stores to a word-wide RAM, sub-word stores
// by read-modify-write. Define MEMORIA_MISALIGN_CHECK_EN to reject misaligned half/word accesses.
module controlador_memoria_dado
    import pacote_memoria_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic              signed_ld,
    input  logic [ADDR_W+1:0] byte_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    estado_t           st;
    logic              rw_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [1:0]        lane_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rej_q;
    logic              illegal;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    always_comb begin
        illegal = (size == SZ_ILLEGAL);
`ifdef MEMORIA_MISALIGN_CHECK_EN
        if (size == SZ_HALF && byte_addr[0])
            illegal = 1'b1;
        if (size == SZ_WORD && byte_addr[1:0] != 2'b00)
            illegal = 1'b1;
`endif
    end

    alinhador_dado u_alinhador (
        .size      (size_q),
        .lane      (lane_q),
        .signed_ld (sgn_q),
        .word      (mem_q),
        .wdata     (wdata_q),
        .load_val  (load_val),
        .merged    (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= ST_IDLE;
            rw_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            sgn_q       <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            rej_q       <= 1'b0;
            rdata       <= '0;
            ack         <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_we      <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (req) begin
                        rw_q        <= rw;
                        size_q      <= size;
                        sgn_q       <= signed_ld;
                        lane_q      <= byte_addr[1:0];
                        wdata_q     <= wdata;
                        mem_address <= byte_addr[ADDR_W+1:2];
                        busy        <= 1'b1;
                        rej_q       <= illegal;
                        if (illegal) begin
                            st <= ST_DONE;
                        end else if (rw && size == SZ_WORD) begin
                            // Full-word store needs no read: go straight to the write cycle.
                            mem_data <= wdata;
                            mem_we   <= 1'b1;
                            st       <= ST_WRITE;
                        end else begin
                            st <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (rw_q) begin
                        mem_data <= merged;
                        mem_we   <= 1'b1;
                        st       <= ST_WRITE;
                    end else begin
                        rdata <= load_val;
                        st    <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    mem_we <= 1'b0;
                    st     <= ST_DONE;
                end
                ST_DONE: begin
                    ack  <= 1'b1;
                    err  <= rej_q;
                    busy <= 1'b0;
                    st   <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule
